muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file. It consumes the two read operands (reg1/reg2) plus funct3 and produces a 32-bit result for the writeback path. It uses a start/busy/done handshake so the control unit can stall while the operation runs.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 25 ++
 rtl/muldiv_unit.sv | 98 +++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add multiply or restoring divide iteration.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              i_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;
    // Multiply: {hi,lo} with the multiplier in lo; divide: {rem,quot} with the dividend in quot.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_acc[0] ? i_opnd : {XLEN{1'b0}}};
        w_shift = i_acc[2*XLEN-1:XLEN-1];
        w_ge    = w_shift >= {1'b0, i_opnd};
        w_diff  = w_shift[XLEN-1:0] - i_opnd;
        o_acc   = i_div ? {w_ge ? w_diff : w_shift[XLEN-1:0], i_acc[XLEN-2:0], w_ge}
                        : {w_sum, i_acc[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit with start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    muldiv_state_e     r_state;
    muldiv_op_e        r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
    logic              r_neg_a;
    logic              w_div, w_sa, w_sb, w_neg_a, w_neg_b, w_dz, w_ovf, w_fastpath, w_last;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast, w_q, w_rem, w_fin;
    logic [2*XLEN-1:0] w_next, w_prod;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_div  (r_op[2]),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_next)
    );

    always_comb begin
        w_div      = funct3[2];
        w_sa       = w_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        w_sb       = w_div ? ~funct3[0] : ~funct3[1];
        w_neg_a    = w_sa & op_a[XLEN-1];
        w_neg_b    = w_sb & op_b[XLEN-1];
        w_mag_a    = w_neg_a ? -op_a : op_a;
        w_mag_b    = w_neg_b ? -op_b : op_b;
        w_dz       = w_div & (op_b == '0);
        w_ovf      = w_div & ~funct3[0] & (op_a == DIV_OVF_DIVIDEND) & (op_b == '1);
        w_fastpath = w_dz | w_ovf;
        w_fast     = w_dz ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : DIV_OVF_DIVIDEND);
        w_last     = r_cnt == CW'(XLEN - 1);
        // Sign fix is applied to the last iteration's output so the result registers on that edge.
        w_prod     = r_neg ? -w_next : w_next;
        w_q        = r_neg ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
        w_rem      = r_neg_a ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];
        w_fin      = r_op[2] ? (r_op[1] ? w_rem : w_q)
                             : (r_op == OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_neg_a  <= 1'b0;
        end else if (r_state == RUN) begin
            if (flush) begin
                r_state <= IDLE;
            end else begin
                r_acc <= w_next;
                if (w_last) begin
                    r_result <= w_fin;
                    r_state  <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end else if (start && !flush) begin
            r_op    <= muldiv_op_e'(funct3);
            r_opnd  <= w_div ? w_mag_b : w_mag_a;
            r_acc   <= {{XLEN{1'b0}}, w_div ? w_mag_a : w_mag_b};
            r_cnt   <= '0;
            r_neg   <= w_neg_a ^ w_neg_b;
            r_neg_a <= w_neg_a;
            r_state <= w_fastpath ? DONE : RUN;
            if (w_fastpath) r_result <= w_fast;
        end else begin
            r_state <= IDLE;
        end
    end

    assign busy   = r_state == RUN;
    assign done   = r_state == DONE;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    int          errors = 0;
    int          checks = 0;

    muldiv_unit dut (
        .clk    (clk),
        .res    (res),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Leaves the bench at the negedge of cycle 1 (first cycle after the accepting edge).
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic saw_busy);
        lat = 0;
        saw_busy = busy;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            saw_busy |= busy;
        end
    endtask

    task automatic test_reset;
        #2 res = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_mul_timing;
        int bad = 0;
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mul_busy_window: got %0d bad cycles want 0", bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done_c33: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_c33: got %b want 0", busy); end
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", result); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_c34: got %b want 0", done); end
    endtask

    task automatic test_ops;
        logic [2:0]  vf [7] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] va [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] vb [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ve [7] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat;
        logic sb;
        for (int i = 0; i < 7; i++) begin
            launch(vf[i], va[i], vb[i]);
            wait_done(lat, sb);
            checks++; if (lat != 32) begin errors++; $display("FAIL op%0d_latency: got %0d want 32", i, lat); end
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL op%0d_result f3=%b: got %h want %h", i, vf[i], result, ve[i]); end
        end
    endtask

    task automatic test_fast;
        logic [2:0]  vf [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] va [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ve [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            launch(vf[i], va[i], vb[i]);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL fast%0d_done_c1: got %b want 1", i, done); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fast%0d_busy_c1: got %b want 0", i, busy); end
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL fast%0d_result: got %h want %h", i, result, ve[i]); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fast%0d_c2: got done=%b busy=%b want 0/0", i, done, busy); end
        end
    endtask

    task automatic test_flush;
        int lat;
        logic sb;
        logic seen = 1'b0;
        launch(3'b101, 32'd100, 32'd7);
        wait_done(lat, sb);
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_pre_result: got %h want 0000000e", result); end
        launch(3'b101, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_c11: got %b want 0", busy); end
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result_kept: got %h want 0000000e", result); end
        for (int c = 0; c < 40; c++) begin
            seen |= done | busy;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got activity=%b want 0", seen); end
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b000;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_drops_start: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        launch(3'b000, 32'h1234, 32'h5678);
        repeat (5) @(negedge clk);
        #2 res = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", result); end
        #1 res = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            seen |= done | busy;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got activity=%b want 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic sb;
        @(negedge clk);
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd4;
        start  = 1'b1;
        @(negedge clk);
        wait_done(lat, sb);
        checks++; if (lat != 32) begin errors++; $display("FAIL b2b_first_latency: got %0d want 32", lat); end
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL b2b_first_result: got %h want 0000000c", result); end
        op_a = 32'd5;
        op_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
        wait_done(lat, sb);
        checks++; if (lat != 32) begin errors++; $display("FAIL b2b_second_latency: got %0d want 32", lat); end
        checks++; if (result !== 32'd30) begin errors++; $display("FAIL b2b_second_result: got %h want 0000001e", result); end
    endtask

    task automatic test_ignored_start;
        int lat;
        logic sb;
        logic seen = 1'b0;
        launch(3'b000, 32'd9, 32'd9);
        repeat (3) @(negedge clk);
        op_a  = 32'd2;
        op_b  = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, sb);
        checks++; if (lat != 17) begin errors++; $display("FAIL ign_latency: got %0d want 17", lat); end
        checks++; if (result !== 32'd81) begin errors++; $display("FAIL ign_result: got %h want 00000051", result); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen |= done | busy;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ign_not_queued: got activity=%b want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_mul_timing;
        test_ops;
        test_fast;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        test_ignored_start;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
